// File: rtl/multi_mode_shift_reg.sv
// Loadable DW-bit register doing multi-cycle rotate/shift, one position per clock.
// Latency: amt+1 edges from start to done pulse; amt=0 reports done on the next cycle.
// Backpressure: none; start is ignored while busy, load aborts any operation.
module multi_mode_shift_reg #(
    parameter int DW = 8,
    parameter int AW = $clog2(DW)
) (
    input  logic          clk,
    input  logic          async_rst_n,
    input  logic          load,
    input  logic [DW-1:0] data,
    input  logic          start,
    input  logic [AW-1:0] amt,
    input  logic          dir,
    input  logic [1:0]    mode,
    input  logic          sin,
    output logic [DW-1:0] q,
    output logic          sout,
    output logic          busy,
    output logic          done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] shreg_q, shreg_d;
    logic          sout_q,  sout_d;
    logic          done_q,  done_d;
    logic [AW-1:0] cnt_q,   cnt_d;
    logic [1:0]    mode_q,  mode_d;
    logic          dir_q,   dir_d;
    logic [AW-1:0] amt_q,   amt_d;
    logic          fill;

    // Bit entering the vacated end; depends only on the latched operation.
    always_comb begin
        fill = 1'b0;
        case (mode_q)
            2'b00:   fill = dir_q ? shreg_q[0] : shreg_q[DW-1];
            2'b01:   fill = 1'b0;
            2'b10:   fill = dir_q ? shreg_q[DW-1] : 1'b0;
            default: fill = sin;
        endcase
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        sout_d  = sout_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        dir_d   = dir_q;
        amt_d   = amt_q;

        if (load) begin
            shreg_d = data;
            state_d = IDLE;
        end else if (state_q == IDLE) begin
            if (start) begin
                mode_d = mode;
                dir_d  = dir;
                amt_d  = amt;
                cnt_d  = amt;
                if (amt != '0) begin
                    state_d = RUN;
                end else begin
                    done_d = 1'b1;
                end
            end
        end else begin
            if (dir_q) begin
                shreg_d = {fill, shreg_q[DW-1:1]};
                sout_d  = shreg_q[0];
            end else begin
                shreg_d = {shreg_q[DW-2:0], fill};
                sout_d  = shreg_q[DW-1];
            end
            cnt_d = cnt_q - AW'(1);
            if (cnt_q == AW'(1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            sout_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            mode_q  <= 2'b00;
            dir_q   <= 1'b0;
            amt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            sout_q  <= sout_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            amt_q   <= amt_d;
        end
    end

    assign q    = shreg_q;
    assign sout = sout_q;
    assign busy = (state_q == RUN);
    assign done = done_q;

endmodule

// File: tb/tb_multi_mode_shift_reg.sv
// Directed bench for multi_mode_shift_reg with hand-computed expected values.
module tb_multi_mode_shift_reg;

    localparam int DW = 8;
    localparam int AW = 3;

    logic          clk;
    logic          async_rst_n;
    logic          load;
    logic [DW-1:0] data;
    logic          start;
    logic [AW-1:0] amt;
    logic          dir;
    logic [1:0]    mode;
    logic          sin;
    logic [DW-1:0] q;
    logic          sout;
    logic          busy;
    logic          done;

    int n_tests = 0;
    int n_fail  = 0;

    multi_mode_shift_reg #(.DW(DW), .AW(AW)) dut (
        .clk         (clk),
        .async_rst_n (async_rst_n),
        .load        (load),
        .data        (data),
        .start       (start),
        .amt         (amt),
        .dir         (dir),
        .mode        (mode),
        .sin         (sin),
        .q           (q),
        .sout        (sout),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [DW-1:0] v);
        data = v;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic do_start(input logic [1:0] m, input logic d, input logic [AW-1:0] a);
        mode  = m;
        dir   = d;
        amt   = a;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        logic saw_done;
        async_rst_n = 1'b0;
        load = 1'b0; data = '0; start = 1'b0; amt = '0;
        dir = 1'b0; mode = 2'b00; sin = 1'b0;
        #12;
        chk("rst_q", q, 8'h00);
        chk("rst_sout", sout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        async_rst_n = 1'b1;

        // Rotate left by 3
        do_load(8'h96);
        chk("load_q", q, 8'h96);
        do_start(2'b00, 1'b0, 3'd3);
        chk("rol_e0_busy", busy, 1);
        chk("rol_e0_q", q, 8'h96);
        chk("rol_e0_done", done, 0);
        tick(); chk("rol_e1_q", q, 8'h2D);
        tick(); chk("rol_e2_q", q, 8'h5A); chk("rol_e2_busy", busy, 1);
        tick(); chk("rol_e3_q", q, 8'hB4);
        chk("rol_e3_done", done, 1); chk("rol_e3_busy", busy, 0); chk("rol_sout", sout, 0);
        tick(); chk("rol_done_drop", done, 0);

        // Arithmetic right by 2
        do_load(8'h96);
        do_start(2'b10, 1'b1, 3'd2);
        tick(); chk("asr_e1_q", q, 8'hCB);
        tick(); chk("asr_e2_q", q, 8'hE5); chk("asr_done", done, 1); chk("asr_sout", sout, 1);

        // Logical right by 2
        do_load(8'h96);
        do_start(2'b01, 1'b1, 3'd2);
        tick(); chk("lsr_e1_q", q, 8'h4B);
        tick(); chk("lsr_e2_q", q, 8'h25); chk("lsr_done", done, 1); chk("lsr_sout", sout, 1);

        // Serial-in right by 3, then amt=0
        do_load(8'h00);
        sin = 1'b1;
        do_start(2'b11, 1'b1, 3'd3);
        tick(); chk("ser_e1_q", q, 8'h80);
        tick(); chk("ser_e2_q", q, 8'hC0);
        tick(); chk("ser_e3_q", q, 8'hE0); chk("ser_done", done, 1);
        tick(); chk("ser_idle_done", done, 0);
        do_start(2'b11, 1'b1, 3'd0);
        chk("amt0_done", done, 1); chk("amt0_busy", busy, 0); chk("amt0_q", q, 8'hE0);
        tick(); chk("amt0_done_drop", done, 0);
        sin = 1'b0;

        // Abort: start ignored mid-run, load aborts without done
        do_load(8'hFF);
        do_start(2'b01, 1'b0, 3'd5);
        tick(); chk("abt_e1_q", q, 8'hFE);
        mode = 2'b00; dir = 1'b1; amt = 3'd1; start = 1'b1;
        tick(); chk("abt_e2_q", q, 8'hFC); chk("abt_e2_busy", busy, 1); chk("abt_e2_done", done, 0);
        start = 1'b0;
        do_load(8'h3C);
        chk("abt_q", q, 8'h3C); chk("abt_busy", busy, 0); chk("abt_sout", sout, 1);
        saw_done = done;
        for (int i = 0; i < 8; i++) begin
            tick();
            saw_done = saw_done | done;
        end
        chk("abt_no_done", saw_done, 0);
        chk("abt_q_hold", q, 8'h3C);

        // Async reset mid-rotate
        do_load(8'hA5);
        do_start(2'b00, 1'b0, 3'd6);
        tick(); tick(); tick();
        chk("ar_pre_q", q, 8'h2D); chk("ar_pre_sout", sout, 1);
        #2 async_rst_n = 1'b0;
        #1;
        chk("ar_q", q, 8'h00); chk("ar_sout", sout, 0);
        chk("ar_busy", busy, 0); chk("ar_done", done, 0);
        @(negedge clk);
        async_rst_n = 1'b1;
        tick(); chk("ar_post_done", done, 0);
        do_load(8'h81);
        do_start(2'b00, 1'b0, 3'd1);
        chk("ar_run_busy", busy, 1);
        tick(); chk("ar_run_q", q, 8'h03); chk("ar_run_done", done, 1); chk("ar_run_sout", sout, 1);

        // Back-to-back start in the done cycle
        do_load(8'h01);
        do_start(2'b00, 1'b0, 3'd1);
        tick(); chk("b2b_e1_q", q, 8'h02); chk("b2b_e1_done", done, 1);
        do_start(2'b00, 1'b0, 3'd1);
        chk("b2b_e2_busy", busy, 1); chk("b2b_e2_done", done, 0); chk("b2b_e2_q", q, 8'h02);
        tick(); chk("b2b_e3_q", q, 8'h04); chk("b2b_e3_done", done, 1); chk("b2b_e3_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_mode_shift_reg.md
# multi_mode_shift_reg

Parametrised successor to the single-step left-rotate register. It loads a DW-bit word, then performs a multi-cycle shift or rotate of 0..DW-1 positions, one position per clock. Direction and mode are selected per operation, and the block reports progress through a start/busy/done handshake. It sits in datapaths that need bit-serialisation, normalisation or rotation without a full combinational barrel shifter.

## Interface
- DW, 8, data width (≥2)
- AW, $clog2(DW), width of the shift-amount port
- clk  in  1  rising-edge clock
- async_rst_n  in  1  asynchronous active-low reset
- load  in  1  parallel load of data into q (highest priority)
- data  in  DW  parallel load value
- start  in  1  begin an operation; sampled only when idle and load=0
- amt  in  AW  number of single-position steps (0..DW-1); latched at start
- dir  in  1  0 = toward MSB (left), 1 = toward LSB (right); latched at start
- mode  in  2  00 rotate, 01 logical shift (fill 0), 10 arithmetic (right: fill q[DW-1]; left: same as logical), 11 serial shift (fill sin); latched at start
- sin  in  1  serial fill bit for mode 11, sampled on every step
- q  out  DW  register contents
- sout  out  1  registered copy of the last bit shifted or rotated out
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse when an operation completes

## Operation
- Clock is clk. Reset is async_rst_n, asynchronous and active-low.
- Reset values: q=0, sout=0, busy=0, done=0. The internal step counter, mode, dir and amt registers are also cleared.
- States: IDLE (busy=0) and RUN (busy=1).
- Priority at each edge: load > start > step.
- load=1 in any state:
  - q<=data, state<=IDLE, done<=0, sout unchanged.
  - An operation in progress is aborted with no done pulse.
- IDLE, start=1, load=0:
  - mode, dir and amt are latched and cnt<=amt.
  - amt≠0: go to RUN, q unchanged.
  - amt=0: stay in IDLE, done<=1 on this edge, q and sout unchanged.
- RUN, each edge with load=0 performs one step:
  - left: q<={q[DW-2:0],fill}, sout<=q[DW-1]
  - right: q<={fill,q[DW-1:1]}, sout<=q[0]
  - rotate fill is the bit shifted out (q[DW-1] for left, q[0] for right).
  - cnt decrements. On the step where cnt==1, go to IDLE and set done<=1.
- start asserted in RUN is ignored; it is neither queued nor restarted.
- Changes to amt, dir or mode during RUN have no effect.
- sin changes take effect on the next step.
- done is high for exactly one cycle per completed operation and is otherwise 0.

## Timing
- start sampled at edge E0 with amt=N>0:
  - busy is high after E0 through EN.
  - q changes at E1..EN.
  - busy falls and done rises after EN.
  - done drops after EN+1.
  - Latency from start edge to done is N+1 edges.
- amt=0: done is high for the single cycle after E0, and busy stays 0.
- Back-to-back: start may be asserted in the cycle done is high. It is accepted at that edge because the block is idle.
- Assertion of async_rst_n low is immediate and needs no clock. Deassertion is synchronous to the next clk edge by external synchroniser.
- Reset mid-RUN: all outputs return to reset values immediately, and no done pulse is issued.
- No combinational path from any input to any output.

## Test plan
- Rotate left, DW=8: load 0x96, then start mode=00 dir=0 amt=3 → q=0x2D, 0x5A, 0xB4 on E1..E3; busy high for 3 cycles; done pulse after E3; sout=0.
- Arithmetic right: load 0x96, then start mode=10 dir=1 amt=2 → q=0xCB then 0xE5; sout=1; done after E2. Repeat with mode=01 → q=0x4B then 0x25.
- Serial-in right: load 0x00, sin=1, start mode=11 dir=1 amt=3 → q=0x80, 0xC0, 0xE0; then amt=0 start → done next cycle, q=0xE0, busy=0.
- Abort and ignore: start amt=5 on 0xFF with mode=01 dir=0; start re-asserted at step 2 is ignored; load data=0x3C at step 3 → q=0x3C, busy=0, no done pulse ever issued for the aborted operation.
- Async reset mid-RUN: drop async_rst_n between edges during a 6-step rotate → q=0, sout=0, busy=0, done=0 immediately. After release, the first start completes normally.
- Back-to-back: start in the done cycle with amt=1 → second done exactly 2 edges later, no idle gap.
